// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// The key map turns a latched {row, col} pair into the hex digit printed on the keypad.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_e;

    // Entry {row, col}; row 3 holds E 0 F D, row 0 holds 1 2 3 A.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Flops reset to the idle (pulled-up) level so no phantom press appears after reset.
module sync2 #(
    parameter int   WIDTH     = 4,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= {WIDTH{RESET_VAL}};
            sync_q <= {WIDTH{RESET_VAL}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader: one debounced key_valid strobe per press,
// key_held until the release has been debounced.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4800,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [ROWS-1:0] rs;

    state_e           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [DIV_W-1:0] dwell_q, dwell_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;

    logic             single_low;
    logic [1:0]       low_row;
    logic [ROWS-1:0]  row_pat;
    logic             row_bit;

    sync2 #(
        .WIDTH     (ROWS),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rows),
        .q_o   (rs)
    );

    // A press is only trusted when exactly one row is low; ghosting from
    // multi-key combinations is discarded here.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        single_low = 1'b1;
        low_row    = 2'd0;
        case (rs)
            4'b1110: low_row = 2'd0;
            4'b1101: low_row = 2'd1;
            4'b1011: low_row = 2'd2;
            4'b0111: low_row = 2'd3;
            default: single_low = 1'b0;
        endcase
    end

    assign row_pat = ~(4'b0001 << row_q);
    assign row_bit = rs[row_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            dwell_q <= '0;
            deb_q   <= '0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            deb_q   <= deb_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        deb_d   = deb_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;

        case (state_q)
            SCAN: begin
                if (dwell_q == DIV_LAST) begin
                    dwell_d = '0;
                    if (single_low) begin
                        row_d   = low_row;
                        deb_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DIV_W'(1);
                end
            end

            DEBOUNCE: begin
                if (rs == row_pat) begin
                    if (deb_q == DEB_LAST) begin
                        deb_d   = '0;
                        code_d  = key_lookup(row_q, col_q);
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        state_d = HELD;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end else begin
                    deb_d   = '0;
                    dwell_d = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end
            end

            // Only the latched row bit matters while a key is down.
            HELD: begin
                if (row_bit) begin
                    deb_d   = '0;
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                if (row_bit) begin
                    if (deb_q == DEB_LAST) begin
                        deb_d   = '0;
                        held_d  = 1'b0;
                        dwell_d = '0;
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end else begin
                    deb_d   = '0;
                    state_d = HELD;
                end
            end

            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        cols      = ~(4'b0001 << col_q);
        key_code  = code_q;
        key_valid = valid_q;
        key_held  = held_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed scenarios for keypad_scanner; expected key codes are queued at stimulus
// time and popped by an independent monitor on every key_valid strobe.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;       // pressed switches, index row*4+col
    logic [3:0]  force_low;  // row glitch injection, independent of column

    int errors  = 0;
    int checks  = 0;
    int strobes = 0;
    logic [3:0] exp_q[$];

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad: a row reads low when a closed switch joins it to the driven column.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            rows[r] = ~((|(keys[r*4 +: 4] & ~cols)) | force_low[r]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_held(input logic val, input int max_cycles, output int n);
        n = 0;
        while (key_held !== val && n < max_cycles) begin
            tick(1);
            n++;
        end
        check(val ? "held_rise" : "held_fall", key_held, val);
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            strobes++;
            check("strobe_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("key_code_on_strobe", key_code, exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        logic [3:0] exp_cols;

        reset     = 1'b1;
        keys      = 16'h0;
        force_low = 4'h0;
        tick(3);
        check("rst_cols", cols, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        reset = 1'b0;

        // Idle scan: four cycles per column, wrapping 3 -> 0.
        for (int k = 0; k < 16; k++) begin
            exp_cols = 4'b1111;
            exp_cols[(k / 4) % 4] = 1'b0;
            check("idle_cols", cols, exp_cols);
            tick(1);
        end

        // Key "5": row 1, column 1.
        exp_q.push_back(4'h5);
        keys[5] = 1'b1;
        wait_held(1'b1, 60, n);
        check("k5_cols_frozen", cols, 4'b1101);
        check("k5_code", key_code, 4'h5);
        if (n < 40) tick(40 - n);
        check("k5_cols_still_frozen", cols, 4'b1101);
        keys[5] = 1'b0;
        wait_held(1'b0, 40, n);
        check("k5_release_cycles", n, 19);
        check("k5_next_col", cols, 4'b1011);

        // 6-cycle glitch on row 0 while column 2 dwells.
        force_low = 4'b0001;
        tick(6);
        force_low = 4'b0000;
        n = 0;
        while (cols === 4'b1011 && n < 30) begin
            tick(1);
            n++;
        end
        check("glitch_resume_col3", cols, 4'b0111);
        check("glitch_no_held", key_held, 1'b0);

        // Key "D" with a release bounce.
        exp_q.push_back(4'hD);
        keys[15] = 1'b1;
        wait_held(1'b1, 60, n);
        check("kd_cols_frozen", cols, 4'b0111);
        check("kd_code", key_code, 4'hD);
        tick(10);
        keys[15] = 1'b0;
        tick(3);
        keys[15] = 1'b1;
        tick(5);
        check("kd_bounce_held", key_held, 1'b1);
        keys[15] = 1'b0;
        wait_held(1'b0, 40, n);
        check("kd_release_cycles", n, 19);
        check("kd_wrap_col0", cols, 4'b1110);

        // Two keys in column 0 are ignored until one lifts.
        keys[0] = 1'b1;
        keys[8] = 1'b1;
        tick(40);
        check("multi_no_held", key_held, 1'b0);
        exp_q.push_back(4'h1);
        keys[8] = 1'b0;
        wait_held(1'b1, 60, n);
        check("k1_code", key_code, 4'h1);
        check("k1_cols_frozen", cols, 4'b1110);
        keys[0] = 1'b0;
        wait_held(1'b0, 40, n);
        check("k1_release_cycles", n, 19);

        // Reset while "9" is held, key kept pressed across reset.
        exp_q.push_back(4'h9);
        keys[10] = 1'b1;
        wait_held(1'b1, 60, n);
        check("k9_code", key_code, 4'h9);
        tick(5);
        reset = 1'b1;
        tick(1);
        check("midrst_cols", cols, 4'b1110);
        check("midrst_code", key_code, 4'h0);
        check("midrst_valid", key_valid, 1'b0);
        check("midrst_held", key_held, 1'b0);
        exp_q.push_back(4'h9);
        reset = 1'b0;
        wait_held(1'b1, 80, n);
        check("k9_redetect_code", key_code, 4'h9);
        check("k9_redetect_cols", cols, 4'b1011);
        keys[10] = 1'b0;
        wait_held(1'b0, 40, n);
        check("k9_release_cycles", n, 19);

        tick(10);
        check("scoreboard_drained", exp_q.size(), 0);
        check("strobe_total", strobes, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
